// File: rtl/pong_pkg.sv
// Shared types and default tuning values for the pong serve/ball stages.
package pong_pkg;

    localparam int SERVE_SPD_W     = 3;
    localparam int DEF_MIN_SPD_Y   = 1;
    localparam int DEF_SERVE_DELAY = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        OFFER = 2'd2,
        PLAY  = 2'd3
    } serve_state_e;

    typedef struct packed {
        logic                   dir_x;
        logic                   dir_y;
        logic [SERVE_SPD_W-1:0] speed_y;
    } serve_t;

endpackage

// File: rtl/config.svh
// Build-wide configuration shared by the pong datapath blocks.
`ifndef CONFIG_SVH
`define CONFIG_SVH

`define RND_NUM_W 8

`endif

// File: rtl/ball_serve.sv
// Serve generator: holds the ball for a frame-counted delay, then offers a random serve vector.
// Optional macro SERVE_ALT_EN: serve direction alternates instead of following the scoring side.
`include "config.svh"

module ball_serve
    import pong_pkg::*;
#(
    parameter int RND_W       = `RND_NUM_W,
    parameter int SPD_W       = SERVE_SPD_W,
    parameter int MIN_SPD_Y   = DEF_MIN_SPD_Y,
    parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [RND_W-1:0] rnd_num_i,
    input  logic             frame_i,
    input  logic             start_i,
    input  logic             score_l_i,
    input  logic             score_r_i,
    output logic             serve_valid_o,
    input  logic             serve_ready_i,
    output logic             serve_dir_x_o,
    output logic             serve_dir_y_o,
    output logic [SPD_W-1:0] serve_speed_y_o,
    output logic             serving_o
);

    localparam int CNT_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;

    serve_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    serve_t           pay_q, pay_d;
    logic [SPD_W-1:0] raw_s;
    logic [SPD_W-1:0] spd_s;

    // Vertical speed candidate, clamped so a serve is never flat.
    always_comb begin
        raw_s = rnd_num_i[SPD_W-1:0];
        if (raw_s < SPD_W'(MIN_SPD_Y)) begin
            spd_s = SPD_W'(MIN_SPD_Y);
        end else begin
            spd_s = raw_s;
        end
    end

`ifdef SERVE_ALT_EN
    logic alt_q, alt_d;
`endif

    // Next-state, delay counter and payload update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
`ifdef SERVE_ALT_EN
        alt_d   = alt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = DELAY;
                    cnt_d       = CNT_W'(SERVE_DELAY);
                    pay_d.dir_x = rnd_num_i[0];
`ifdef SERVE_ALT_EN
                    alt_d       = rnd_num_i[0];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d       = OFFER;
                    pay_d.dir_y   = rnd_num_i[RND_W-1];
                    pay_d.speed_y = SERVE_SPD_W'(spd_s);
                end else if (frame_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            OFFER: begin
                if (serve_ready_i) begin
                    state_d = PLAY;
`ifdef SERVE_ALT_EN
                    alt_d   = ~alt_q;
`endif
                end else begin
                    state_d = OFFER;
                end
            end
            PLAY: begin
                // Left score wins a same-cycle tie; ball goes toward the player who conceded.
                if (score_l_i || score_r_i) begin
                    state_d     = DELAY;
                    cnt_d       = CNT_W'(SERVE_DELAY);
`ifdef SERVE_ALT_EN
                    pay_d.dir_x = alt_q;
`else
                    pay_d.dir_x = ~score_l_i;
`endif
                end else begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and payload registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
        end
    end

`ifdef SERVE_ALT_EN
    // Direction for the next serve after a point.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alt_q <= 1'b0;
        end else begin
            alt_q <= alt_d;
        end
    end
`endif

    assign serve_valid_o   = (state_q == OFFER);
    assign serving_o       = (state_q != PLAY);
    assign serve_dir_x_o   = pay_q.dir_x;
    assign serve_dir_y_o   = pay_q.dir_y;
    assign serve_speed_y_o = SPD_W'(pay_q.speed_y);

endmodule
